// File: rtl/wez_reg_pkg.sv
// Shared types and the in-place operation unit for the wez register bank.
// apply_op works on a MAX_W-wide container; callers slice out their own WIDTH.
package wez_reg_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_CLR  = 3'd6,
        OP_NOT  = 3'd7
    } op_t;

    // Returns {carry, result}; result bits at or above w are forced to zero.
    function automatic logic [MAX_W:0] apply_op(
        input op_t                op,
        input logic [MAX_W-1:0]   r,
        input logic [MAX_W-1:0]   d,
        input int unsigned        w
    );
        logic [MAX_W:0] mask;
        logic [MAX_W:0] res;
        logic [MAX_W:0] sh;
        logic           carry;
        mask  = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        res   = '0;
        sh    = '0;
        carry = 1'b0;
        case (op)
            OP_LOAD: res = {1'b0, d};
            OP_INC: begin
                res   = {1'b0, r} + (MAX_W+1)'(1);
                sh    = res >> w;
                carry = sh[0];
            end
            OP_DEC: begin
                res   = {1'b0, r} - (MAX_W+1)'(1);
                carry = (r == '0);
            end
            OP_ADD: begin
                res   = {1'b0, r} + {1'b0, d};
                sh    = res >> w;
                carry = sh[0];
            end
            OP_SHL: begin
                res   = {r, d[0]};
                sh    = {1'b0, r} >> (w - 1);
                carry = sh[0];
            end
            OP_SHR: begin
                res   = {2'b00, r[MAX_W-1:1]} | ({{MAX_W{1'b0}}, d[0]} << (w - 1));
                carry = r[0];
            end
            OP_CLR:  res = '0;
            OP_NOT:  res = {1'b0, ~r};
            default: res = '0;
        endcase
        return {carry, res[MAX_W-1:0] & mask[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/wez_reg_cell.sv
// One storage register with write enable and asynchronous active-low reset.
module wez_reg_cell
    import wez_reg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= RST_V;
        end else if (we) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/wez_reg_bank.sv
// Register bank with one shared in-place op unit, registered zero/carry flags,
// two combinational read ports and optional write-to-read bypass.
module wez_reg_bank
    import wez_reg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int RESET_VALUE = 0,
    parameter int BYPASS      = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             flag_zero,
    output logic             flag_carry
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] cur_val;
    logic [MAX_W:0]   op_out;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;
    logic             flag_zero_reg;
    logic             flag_carry_reg;

    // Non-power-of-two depths leave unused address codes; those are ignored.
    assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i)) begin
                cur_val = regs[i];
            end
        end
    end

    assign op_out      = apply_op(op_t'(op), MAX_W'(cur_val), MAX_W'(wr_data), WIDTH);
    assign result_next = op_out[WIDTH-1:0];
    assign carry_next  = op_out[MAX_W];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            wez_reg_cell #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_cell (
                .clk (clk),
                .rst (rst),
                .we  (wr_ok && (wr_addr == AW'(gi))),
                .d   (result_next),
                .q   (regs[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_zero_reg  <= 1'b0;
            flag_carry_reg <= 1'b0;
        end else if (wr_ok) begin
            flag_zero_reg  <= (result_next == '0);
            flag_carry_reg <= carry_next;
        end
    end

    assign flag_zero  = flag_zero_reg;
    assign flag_carry = flag_carry_reg;

    // A bypass hit implies an in-range address, since wr_ok already checked it.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == AW'(i)) rd_a = regs[i];
            if (rd_addr_b == AW'(i)) rd_b = regs[i];
        end
        if (BYPASS != 0 && wr_ok && rd_addr_a == wr_addr) rd_a = result_next;
        if (BYPASS != 0 && wr_ok && rd_addr_b == wr_addr) rd_b = result_next;
    end

endmodule

// File: tb/tb_wez_reg_bank.sv
// Scoreboard bench for wez_reg_bank: one non-bypass and one bypass build share
// the same stimulus; expected results are queued at drive time.
module tb_wez_reg_bank;
    import wez_reg_pkg::*;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [2:0]    op = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic [W-1:0]  rd_a0, rd_b0, rd_a1, rd_b1;
    logic          z0, c0, z1, c1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  val;
        logic          z;
        logic          c;
    } exp_t;

    typedef struct {
        op_t           o;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic [W-1:0]  v;
        logic          z;
        logic          c;
    } step_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wez_reg_bank #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .op(op),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_a(rd_a0), .rd_b(rd_b0), .flag_zero(z0), .flag_carry(c0)
    );

    wez_reg_bank #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(0), .BYPASS(1)) dut_bp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .op(op),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_a(rd_a1), .rd_b(rd_b1), .flag_zero(z1), .flag_carry(c1)
    );

    // Drives one op across a rising edge and queues its expected outcome.
    task automatic drive_op(input step_t s, input bit keep_en);
        exp_t e;
        @(negedge clk);
        op = s.o; wr_addr = s.a; wr_data = s.d; wr_en = 1'b1; rd_addr_a = s.a;
        e.addr = s.a; e.val = s.v; e.z = s.z; e.c = s.c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep_en) wr_en = 1'b0;
        #1;
        $display("op=%0d addr=%0d data=%02h -> rd_a=%02h zero=%0b carry=%0b",
                 s.o, s.a, s.d, rd_a0, z0, c0);
    endtask

    task automatic test_reset();
        step_t s;
        exp_t  e;
        repeat (2) @(posedge clk);
        for (int i = 0; i < D; i++) begin
            rd_addr_a = AW'(i);
            #1;
            n_checks++; if (rd_a0 !== 8'h00) begin n_fail++; $display("FAIL reset_val r%0d: got %02h want 00", i, rd_a0); end
        end
        n_checks++; if ({z0, c0} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {z0, c0}); end
        @(negedge clk); rst = 1'b1;
        s = '{OP_LOAD, 2'd0, 8'h55, 8'h55, 1'b0, 1'b0};
        drive_op(s, 1'b0);
        e = sb.pop_front();
        n_checks++; if (rd_a0 !== e.val) begin n_fail++; $display("FAIL reset_load55: got %02h want %02h", rd_a0, e.val); end
        s = '{OP_DEC, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1};
        drive_op(s, 1'b0);
        e = sb.pop_front();
        n_checks++; if ({rd_a0, z0, c0} !== {e.val, e.z, e.c}) begin n_fail++; $display("FAIL reset_dec: got %02h/%b%b want %02h/%b%b", rd_a0, z0, c0, e.val, e.z, e.c); end
        // Assert reset between edges and look before the next edge.
        @(posedge clk); #3;
        rst = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd1;
        #1;
        n_checks++; if (rd_a0 !== 8'h00) begin n_fail++; $display("FAIL async_reset_r0: got %02h want 00", rd_a0); end
        n_checks++; if (rd_b0 !== 8'h00) begin n_fail++; $display("FAIL async_reset_r1: got %02h want 00", rd_b0); end
        n_checks++; if ({z0, c0} !== 2'b00) begin n_fail++; $display("FAIL async_reset_flags: got %b want 00", {z0, c0}); end
        op = OP_LOAD; wr_addr = 2'd0; wr_data = 8'h77; wr_en = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rd_a0 !== 8'h00) begin n_fail++; $display("FAIL reset_discard: got %02h want 00", rd_a0); end
        @(negedge clk); rst = 1'b1; wr_en = 1'b0;
        s = '{OP_LOAD, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0};
        drive_op(s, 1'b0);
        e = sb.pop_front();
        n_checks++; if (rd_a0 !== e.val) begin n_fail++; $display("FAIL release_load11: got %02h want %02h", rd_a0, e.val); end
    endtask

    task automatic test_load_inc();
        step_t tbl[3];
        exp_t  e;
        tbl = '{'{OP_LOAD, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0},
                '{OP_INC,  2'd1, 8'h00, 8'h00, 1'b1, 1'b1},
                '{OP_INC,  2'd1, 8'h00, 8'h01, 1'b0, 1'b0}};
        foreach (tbl[i]) begin
            drive_op(tbl[i], 1'b0);
            e = sb.pop_front();
            n_checks++; if (rd_a0 !== e.val) begin n_fail++; $display("FAIL load_inc[%0d] value: got %02h want %02h", i, rd_a0, e.val); end
            n_checks++; if (rd_a1 !== e.val) begin n_fail++; $display("FAIL load_inc[%0d] value_bp: got %02h want %02h", i, rd_a1, e.val); end
            n_checks++; if ({z0, c0} !== {e.z, e.c}) begin n_fail++; $display("FAIL load_inc[%0d] flags: got %b%b want %b%b", i, z0, c0, e.z, e.c); end
        end
    endtask

    task automatic test_dec_add();
        step_t tbl[4];
        exp_t  e;
        tbl = '{'{OP_DEC,  2'd2, 8'h00, 8'hFF, 1'b0, 1'b1},
                '{OP_ADD,  2'd2, 8'h01, 8'h00, 1'b1, 1'b1},
                '{OP_LOAD, 2'd2, 8'h20, 8'h20, 1'b0, 1'b0},
                '{OP_ADD,  2'd2, 8'h10, 8'h30, 1'b0, 1'b0}};
        foreach (tbl[i]) begin
            drive_op(tbl[i], 1'b0);
            e = sb.pop_front();
            n_checks++; if (rd_a0 !== e.val) begin n_fail++; $display("FAIL dec_add[%0d] value: got %02h want %02h", i, rd_a0, e.val); end
            n_checks++; if ({z0, c0} !== {e.z, e.c}) begin n_fail++; $display("FAIL dec_add[%0d] flags: got %b%b want %b%b", i, z0, c0, e.z, e.c); end
        end
    endtask

    task automatic test_shifts();
        step_t tbl[7];
        exp_t  e;
        tbl = '{'{OP_LOAD, 2'd0, 8'h81, 8'h81, 1'b0, 1'b0},
                '{OP_SHL,  2'd0, 8'h01, 8'h03, 1'b0, 1'b1},
                '{OP_LOAD, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0},
                '{OP_SHR,  2'd0, 8'h00, 8'h00, 1'b1, 1'b1},
                '{OP_LOAD, 2'd0, 8'h0F, 8'h0F, 1'b0, 1'b0},
                '{OP_NOT,  2'd0, 8'h00, 8'hF0, 1'b0, 1'b0},
                '{OP_CLR,  2'd0, 8'hFF, 8'h00, 1'b1, 1'b0}};
        foreach (tbl[i]) begin
            drive_op(tbl[i], 1'b0);
            e = sb.pop_front();
            n_checks++; if (rd_a0 !== e.val) begin n_fail++; $display("FAIL shifts[%0d] value: got %02h want %02h", i, rd_a0, e.val); end
            n_checks++; if ({z0, c0} !== {e.z, e.c}) begin n_fail++; $display("FAIL shifts[%0d] flags: got %b%b want %b%b", i, z0, c0, e.z, e.c); end
        end
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] want [D];
        want = '{8'h00, 8'h01, 8'h30};
        @(negedge clk);
        op = OP_LOAD; wr_addr = 2'd3; wr_data = 8'hAA; wr_en = 1'b1; rd_addr_b = 2'd3;
        #1;
        n_checks++; if (rd_b1 !== 8'h00) begin n_fail++; $display("FAIL oor_read_bp: got %02h want 00", rd_b1); end
        @(posedge clk); #1;
        wr_en = 1'b0;
        $display("op=%0d addr=3 data=aa -> rd_b=%02h zero=%0b carry=%0b", OP_LOAD, rd_b0, z0, c0);
        n_checks++; if (rd_b0 !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %02h want 00", rd_b0); end
        n_checks++; if ({z0, c0} !== 2'b10) begin n_fail++; $display("FAIL oor_flags: got %b%b want 10", z0, c0); end
        for (int i = 0; i < D; i++) begin
            rd_addr_a = AW'(i);
            #1;
            n_checks++; if (rd_a0 !== want[i]) begin n_fail++; $display("FAIL oor_hold r%0d: got %02h want %02h", i, rd_a0, want[i]); end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        @(negedge clk);
        op = OP_LOAD; wr_addr = 2'd2; wr_data = 8'h3C; wr_en = 1'b1;
        rd_addr_a = 2'd2; rd_addr_b = 2'd2;
        e.addr = 2'd2; e.val = 8'h3C; e.z = 1'b0; e.c = 1'b0;
        sb.push_back(e);
        #1;
        n_checks++; if ({rd_a1, rd_b1} !== {8'h3C, 8'h3C}) begin n_fail++; $display("FAIL bypass_on: got %02h/%02h want 3c/3c", rd_a1, rd_b1); end
        n_checks++; if ({rd_a0, rd_b0} !== {8'h30, 8'h30}) begin n_fail++; $display("FAIL bypass_off_old: got %02h/%02h want 30/30", rd_a0, rd_b0); end
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        e = sb.pop_front();
        $display("op=%0d addr=2 data=3c -> rd_a=%02h rd_a_bp=%02h", OP_LOAD, rd_a0, rd_a1);
        n_checks++; if ({rd_a0, rd_b0} !== {e.val, e.val}) begin n_fail++; $display("FAIL bypass_off_after: got %02h/%02h want %02h", rd_a0, rd_b0, e.val); end
        @(negedge clk);
        op = OP_LOAD; wr_data = 8'h99; wr_en = 1'b0;
        #1;
        n_checks++; if ({rd_a0, rd_a1, rd_b1} !== {8'h3C, 8'h3C, 8'h3C}) begin n_fail++; $display("FAIL bypass_wr_en0: got %02h/%02h/%02h want 3c", rd_a0, rd_a1, rd_b1); end
        @(posedge clk); #1;
        $display("op=%0d addr=2 data=99 wr_en=0 -> rd_a=%02h rd_a_bp=%02h", OP_LOAD, rd_a0, rd_a1);
        n_checks++; if ({rd_a0, rd_a1} !== {8'h3C, 8'h3C}) begin n_fail++; $display("FAIL bypass_wr_en0_after: got %02h/%02h want 3c", rd_a0, rd_a1); end
    endtask

    task automatic test_back_to_back();
        step_t tbl[5];
        exp_t  e;
        tbl = '{'{OP_LOAD, 2'd1, 8'h10, 8'h10, 1'b0, 1'b0},
                '{OP_ADD,  2'd1, 8'h05, 8'h15, 1'b0, 1'b0},
                '{OP_INC,  2'd1, 8'h00, 8'h16, 1'b0, 1'b0},
                '{OP_DEC,  2'd1, 8'h00, 8'h15, 1'b0, 1'b0},
                '{OP_SHL,  2'd1, 8'h00, 8'h2A, 1'b0, 1'b0}};
        foreach (tbl[i]) begin
            drive_op(tbl[i], 1'b1);
            e = sb.pop_front();
            n_checks++; if ({rd_a0, z0, c0} !== {e.val, e.z, e.c}) begin n_fail++; $display("FAIL back_to_back[%0d]: got %02h/%b%b want %02h/%b%b", i, rd_a0, z0, c0, e.val, e.z, e.c); end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_inc();
        test_dec_add();
        test_shifts();
        test_out_of_range();
        test_bypass();
        test_back_to_back();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wez_reg_bank.md
# wez_reg_bank

Parametrised bank of write-enabled registers with an in-place operation unit: `DEPTH` registers of `WIDTH` bits, one op/write port and two read ports, plus registered zero and carry flags. It is the next-generation storage element for the CPU datapath. It replaces discrete fixed-width write-enable registers with one block that also supports increment, decrement, add and shift directly in the register, with optional same-cycle write-to-read bypass.

## Interface
- `WIDTH`, 8: bits per register, ≥2.
- `DEPTH`, 4: number of registers, ≥2; need not be a power of two.
- `RESET_VALUE`, 0: value loaded into every register on reset, truncated to `WIDTH`.
- `BYPASS`, 0: 1 = read ports return the in-flight write result when addresses match; 0 = read ports return stored state only.
- `AW`: derived, `$clog2(DEPTH)`; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  apply `op` to register `wr_addr` this cycle.
- `wr_addr`  in  AW  target register.
- `op`  in  3  operation code (see Operation).
- `wr_data`  in  WIDTH  operand for LOAD/ADD; bit 0 is the shift-in bit for SHL/SHR.
- `rd_addr_a`, `rd_addr_b`  in  AW  read addresses.
- `rd_a`, `rd_b`  out  WIDTH  read data, combinational.
- `flag_zero`  out  1  result of the last accepted op was all-zero.
- `flag_carry`  out  1  carry/borrow/shifted-out bit of the last accepted op.

## Operation
- Op codes:
  - 0 LOAD: `r = wr_data`, carry=0.
  - 1 INC: `r+1`, carry = carry-out.
  - 2 DEC: `r-1`, carry = borrow (1 only when r was 0).
  - 3 ADD: `r+wr_data`, carry = carry-out.
  - 4 SHL: `{r[W-2:0], wr_data[0]}`, carry = `r[W-1]`.
  - 5 SHR: `{wr_data[0], r[W-1:1]}`, carry = `r[0]`.
  - 6 CLR: 0, carry=0.
  - 7 NOT: `~r`, carry=0.
- All arithmetic is modulo 2^WIDTH; INC/DEC/ADD wrap silently; the overflow is reported only via `flag_carry`.
- Accepted op: `wr_en=1` and `wr_addr < DEPTH`. Only the addressed register changes; all other registers hold.
- Flags update only on an accepted op. `flag_zero` = (result == 0). Both flags hold otherwise.
- Out-of-range `wr_addr` (≥ DEPTH): no register or flag change.
- Reads:
  - `rd_x` = stored value of `rd_addr_x`.
  - Out-of-range read address returns 0.
  - Both ports may address the same register.
- Bypass:
  - With `BYPASS=1`, an accepted op in progress and `rd_addr_x == wr_addr` make `rd_x` show the op result in the same cycle.
  - With `BYPASS=0`, `rd_x` shows the old value until after the edge.

## Timing
- Reset: `rst` low forces all registers to `RESET_VALUE` and both flags to 0 immediately, without waiting for a clock edge. Read outputs follow combinationally.
- Release: first update is at the first rising edge with `rst` high.
- Reset asserted mid-operation: the pending op is discarded. Nothing is committed on the edge coinciding with reset.
- Write latency: 1 cycle. The result is stored and flags are valid after the rising edge of the cycle with the accepted op.
- Read latency: 0 cycles, combinational from the address. With `BYPASS=1` the path is combinational from `wr_data`/`op`/`wr_en` as well.
- Back-to-back ops on the same register chain correctly, one per cycle. Each op uses the value stored by the previous edge.

## Structure
- Package `wez_reg_pkg`:
  - `op_t` enum (the 8 codes above).
  - `OP_W = 3` constant.
  - Function `apply_op(op, r, d)` returning `{carry, result}`, parametrised by width via the caller's slice.
- Sub-module `wez_reg_cell` (`WIDTH`, `RESET_VALUE`): one register plus its write-enable and async reset. It is instantiated `DEPTH` times via generate.
- Top-level `wez_reg_bank` contains:
  - the single shared op unit,
  - address decode,
  - the flag register,
  - read muxes and the bypass comparators.

## Test plan
Test configuration: `WIDTH=8`, `DEPTH=3`, `RESET_VALUE=0` unless stated.

- **Reset:** drop `rst` between clock edges after loading r0=0x55 → `rd_a`(r0)=0x00 and flags 0 before the next edge. Release `rst`, then LOAD 0x11 → r0=0x11 on the following edge.
- **LOAD/INC wrap:** LOAD 0xFF to r1, then INC r1 → r1=0x00, `flag_zero=1`, `flag_carry=1`. Another INC → 0x01, both flags 0.
- **DEC and ADD:**
  - DEC r2 (0x00) → 0xFF, carry=1, zero=0.
  - ADD 0x01 to r2 → 0x00, carry=1, zero=1.
  - ADD 0x10 to 0x20 → 0x30, carry=0.
- **Shifts:**
  - SHL r0=0x81 with `wr_data[0]=1` → 0x03, carry=1.
  - SHR r0=0x01 with `wr_data[0]=0` → 0x00, carry=1, zero=1.
  - NOT 0x0F → 0xF0.
- **Out-of-range:** `wr_en=1`, `wr_addr=3`, LOAD 0xAA → r0..r2 and flags unchanged. `rd_addr_b=3` → `rd_b=0x00`.
- **Bypass:** LOAD 0x3C to r2 with `rd_addr_a=rd_addr_b=2`:
  - `BYPASS=1` → both read ports show 0x3C in the same cycle.
  - `BYPASS=0` → old value in that cycle, 0x3C after the edge.
  - `wr_en=0` → no bypass in either build.
